// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, IR and OldPC for the multicycle RISC-V datapath.
// Optional misaligned-PC fault via macro FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter int              INST_W   = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start,
    input  logic              pc_write,
    input  logic [XLEN-1:0]   pc_next,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   old_pc,
    output logic              inst_valid,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic              fetch_fault,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] W_STEP = XLEN'(PC_STEP);

    state_t              r_state;
    state_t              w_next;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_old_pc;
    logic [INST_W-1:0]   r_inst;
    logic                r_inst_valid;
    logic                w_start_ok;
    logic                w_idle_wr;
    logic                w_done;

    assign w_idle_wr = (r_state == S_IDLE) && pc_write;
    assign w_done    = (r_state == S_WAIT) && imem_rvalid;

`ifdef FETCH_ALIGN_CHECK_EN
    logic            r_fault;
    logic [XLEN-1:0] w_fetch_pc;
    logic            w_misalign;

    // Fetch address as seen by a same-cycle pc_write; gate starts on alignment
    always_comb begin
        w_fetch_pc = pc_write ? pc_next : r_pc;
        w_misalign = (w_fetch_pc[1:0] != 2'b00);
        w_start_ok = fetch_start && !r_fault && !w_misalign;
    end

    // Sticky fault: set by a misaligned start, cleared by an idle pc_write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (fetch_start && !r_fault && w_misalign)
                r_fault <= 1'b1;
            else if (pc_write)
                r_fault <= 1'b0;
        end
    end

    assign fetch_fault = r_fault;
`else
    assign w_start_ok = fetch_start;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok && (r_state == S_IDLE)) w_next = S_REQ;
            S_REQ:  if (imem_ready) w_next = S_WAIT;
            S_WAIT: if (imem_rvalid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // PC: loaded from the result mux in IDLE, stepped on fetch completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pc <= RESET_PC;
        else if (w_idle_wr)
            r_pc <= pc_next;
        else if (w_done)
            r_pc <= r_pc + W_STEP;
    end

    // Instruction register and OldPC capture on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst   <= '0;
            r_old_pc <= RESET_PC;
        end else if (w_done) begin
            r_inst   <= imem_rdata;
            r_old_pc <= r_pc;
        end
    end

    // inst_valid drops on an accepted start and rises on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_inst_valid <= 1'b0;
        else if (w_done)
            r_inst_valid <= 1'b1;
        else if ((r_state == S_IDLE) && w_start_ok)
            r_inst_valid <= 1'b0;
    end

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_pc;
    assign busy       = (r_state != S_IDLE);
    assign inst       = r_inst;
    assign pc         = r_pc;
    assign old_pc     = r_old_pc;
    assign inst_valid = r_inst_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, corner sequences
// and randomized transactions against a transaction-level PC model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_start;
    logic        pc_write;
    logic [63:0] pc_next;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [63:0] imem_rdata;
    logic [63:0] inst;
    logic [63:0] pc;
    logic [63:0] old_pc;
    logic        inst_valid;
    logic        busy;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int n_pass;
    int n_total;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc_write    (pc_write),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .pc          (pc),
        .old_pc      (old_pc),
        .inst_valid  (inst_valid),
`ifdef FETCH_ALIGN_CHECK_EN
        .fetch_fault (fetch_fault),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [63:0] nxt;
        int          rdly;
        int          vdly;
        logic [63:0] data;
        logic [63:0] noise;
        logic [63:0] eaddr;
        logic [63:0] eold;
        logic [63:0] epc;
    } vec_t;

    vec_t vt [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // One fetch transaction; noise is driven on pc_write/pc_next while busy
    task automatic run_txn(input logic wr, input logic [63:0] nxt,
                           input int rdly, input int vdly,
                           input logic [63:0] data, input logic [63:0] noise,
                           output logic [63:0] addr);
        fetch_start = 1'b1;
        pc_write    = wr;
        pc_next     = nxt;
        tick();
        fetch_start = 1'b0;
        pc_write    = 1'b0;
        chk("req_on", {63'd0, imem_req}, 64'd1);
        chk("valid_clr", {63'd0, inst_valid}, 64'd0);
        addr = imem_addr;
        for (int i = 0; i < rdly; i++) begin
            imem_ready  = 1'b0;
            pc_write    = 1'b1;
            pc_next     = noise;
            fetch_start = 1'b1;
            imem_rvalid = i[0];
            imem_rdata  = ~data;
            tick();
            chk("req_hold", {63'd0, imem_req}, 64'd1);
            chk("addr_hold", imem_addr, addr);
        end
        pc_write    = 1'b0;
        fetch_start = 1'b0;
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        tick();
        imem_ready  = 1'b0;
        chk("wait_noreq", {62'd0, busy, imem_req}, 64'd2);
        for (int i = 0; i < vdly; i++) begin
            pc_write = 1'b1;
            pc_next  = noise;
            tick();
            chk("wait_pc", pc, addr);
        end
        pc_write    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    logic [63:0] a;
    logic [63:0] mpc;
    logic [63:0] mold;
    logic [63:0] minst;
    logic        mwr;
    logic [63:0] mnxt;
    logic [63:0] mdata;

    initial begin
        n_pass = 0;
        n_total = 0;
        fetch_start = 1'b0;
        pc_write    = 1'b0;
        pc_next     = '0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        vt[0] = '{1'b0, 64'h0, 0, 0, 64'h00500093, 64'h0,
                  64'h0, 64'h0, 64'h4};
        vt[1] = '{1'b0, 64'h0, 0, 2, 64'h00a00113, 64'h40,
                  64'h4, 64'h4, 64'h8};
        vt[2] = '{1'b0, 64'h0, 5, 0, 64'h12345678, 64'h100,
                  64'h8, 64'h8, 64'hC};
        vt[3] = '{1'b1, 64'h200, 1, 1, 64'hdeadbeef, 64'h300,
                  64'h200, 64'h200, 64'h204};
        vt[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'hcafe0013,
                  64'h0, 64'hFFFF_FFFF_FFFF_FFFC,
                  64'hFFFF_FFFF_FFFF_FFFC, 64'h0};

        rst = 1'b1;
        #12;
        chk("rst_async_pc", pc, 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_state", {inst_valid, imem_req, busy, 1'b0},
                4'h0);
            chk("idle_pc", pc | old_pc | inst | imem_addr, 64'h0);
        end

        for (int k = 0; k < 5; k++) begin
            run_txn(vt[k].wr, vt[k].nxt, vt[k].rdly, vt[k].vdly,
                    vt[k].data, vt[k].noise, a);
            chk($sformatf("v%0d_addr", k), a, vt[k].eaddr);
            chk($sformatf("v%0d_inst", k), inst, vt[k].data);
            chk($sformatf("v%0d_old", k), old_pc, vt[k].eold);
            chk($sformatf("v%0d_pc", k), pc, vt[k].epc);
            chk($sformatf("v%0d_valid", k),
                {62'd0, inst_valid, busy}, 64'd2);
        end

        imem_rvalid = 1'b1;
        imem_rdata  = 64'h1111;
        tick();
        imem_rvalid = 1'b0;
        tick();
        chk("stray_rvalid_inst", inst, 64'hcafe0013);
        chk("stray_rvalid_valid", {63'd0, inst_valid}, 64'd1);

        pc_write = 1'b1;
        pc_next  = 64'h80;
        tick();
        pc_write = 1'b0;
        chk("idle_pcwr", pc, 64'h80);
        chk("idle_pcwr_valid", {63'd0, inst_valid}, 64'd1);

        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("pre_rst_wait", {63'd0, busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_pc", pc, 64'h0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 64'hbad0bad0;
        tick();
        imem_rvalid = 1'b0;
        chk("late_rv_inst", inst, 64'h0);
        chk("late_rv_pc", pc, 64'h0);
        chk("late_rv_valid", {62'd0, inst_valid, busy}, 64'd0);

`ifdef FETCH_ALIGN_CHECK_EN
        pc_write = 1'b1;
        pc_next  = 64'h6;
        tick();
        pc_write = 1'b0;
        fetch_start = 1'b1;
        tick();
        chk("al_noreq", {62'd0, imem_req, busy}, 64'd0);
        chk("al_fault", {63'd0, fetch_fault}, 64'd1);
        tick();
        fetch_start = 1'b0;
        chk("al_sticky", {62'd0, fetch_fault, imem_req}, 64'd2);
        chk("al_pc", pc, 64'h6);
        pc_write = 1'b1;
        pc_next  = 64'h10;
        tick();
        pc_write = 1'b0;
        chk("al_clear", {63'd0, fetch_fault}, 64'd0);
`endif

        mpc   = pc;
        mold  = old_pc;
        minst = inst;
        for (int t = 0; t < 40; t++) begin
            mwr   = 1'($urandom_range(0, 1));
            mnxt  = {$urandom, $urandom} & ~64'h3;
            if (t % 10 == 9) mnxt = 64'hFFFF_FFFF_FFFF_FFFC;
            mdata = {$urandom, $urandom};
            run_txn(mwr, mnxt, $urandom_range(0, 3), $urandom_range(0, 3),
                    mdata, {$urandom, $urandom} & ~64'h3, a);
            if (mwr) mpc = mnxt;
            chk("r_addr", a, mpc);
            mold  = mpc;
            mpc   = mpc + 64'd4;
            minst = mdata;
            chk("r_inst", inst, minst);
            chk("r_old", old_pc, mold);
            chk("r_pc", pc, mpc);
            chk("r_valid", {63'd0, inst_valid}, 64'd1);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                imem_rvalid = 1'($urandom_range(0, 1));
                imem_rdata  = {$urandom, $urandom};
                pc_write    = 1'($urandom_range(0, 1));
                pc_next     = {$urandom, $urandom} & ~64'h3;
                if (pc_write) mpc = pc_next;
                tick();
                imem_rvalid = 1'b0;
                pc_write    = 1'b0;
                chk("r_idle_pc", pc, mpc);
                chk("r_idle_inst", inst, minst);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream neighbour of the instruction decoder (Control) in the multicycle RISC-V datapath.
- Holds the PC.
- Fetches one instruction word per request over a simple valid/ready instruction-memory port.
- Latches the word into the instruction register that drives Control's inst input.
- Keeps OldPC for branch/JAL/AUIPC target computation.
- Fetch is started by the control FSM; PC updates (PCWrite) come from the datapath result.

Parameters:
XLEN, 64, width of PC and addresses
INST_W, 64, width of instruction register, matches decoder inst input
RESET_PC, 0, PC value after reset
PC_STEP, 4, sequential PC increment applied on each completed fetch

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
fetch_start  in  1  one-cycle request from control FSM to fetch at current pc
pc_write  in  1  load pc from pc_next (PCWrite)
pc_next  in  XLEN  new PC value from result mux
imem_req  out  1  request valid to instruction memory
imem_addr  out  XLEN  fetch address, equals pc while imem_req high
imem_ready  in  1  memory accepts request when high with imem_req
imem_rvalid  in  1  read data valid, one cycle per accepted request
imem_rdata  in  INST_W  instruction word
inst  out  INST_W  instruction register output to decoder
pc  out  XLEN  current PC
old_pc  out  XLEN  PC of instruction held in inst
inst_valid  out  1  inst holds a completed fetch, not yet superseded
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, pc=RESET_PC, old_pc=RESET_PC, inst=0 (opcode 0 matches no decoder case), inst_valid=0, imem_req=0, imem_addr=RESET_PC, busy=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - pc_write=1 → pc<=pc_next.
  - fetch_start=1 → next state REQ, inst_valid<=0.
  - Both in the same cycle: pc loads pc_next and the fetch uses the new pc.
- REQ:
  - imem_req=1, imem_addr=pc, held stable until imem_ready=1.
  - On imem_req&imem_ready → WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: inst<=imem_rdata, old_pc<=pc, pc<=pc+PC_STEP (mod 2^XLEN, wraps silently), inst_valid<=1, → IDLE.
- pc_write and fetch_start are ignored in REQ/WAIT; pc is stable for the whole transaction.
- imem_rvalid outside WAIT is ignored.
- Minimum latency: fetch_start in cycle 0 → imem_req in cycle 1 → rvalid in cycle 2 → inst/inst_valid visible in cycle 3.
- inst holds its value until the next completed fetch. inst_valid stays high until the next fetch_start or reset.
- Reset mid-transaction returns immediately to reset values. A late imem_rvalid after reset is ignored (state IDLE).
- All outputs are registered except imem_addr (=pc), busy (state decode) and imem_req (state decode).

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - fetch_start in IDLE with pc[1:0]!=0 issues no request and stays IDLE; fetch_fault<=1, inst/old_pc/pc unchanged.
  - fetch_fault is sticky; cleared by pc_write in IDLE or by reset.
  - fetch_start while fetch_fault=1 is ignored.
- Not defined: no fetch_fault port; low PC bits are not checked and the address is driven as-is.

Test Plan:
- Reset release, no stimulus → pc=0, old_pc=0, inst=0, inst_valid=0, imem_req=0 for 10 cycles.
- fetch_start at pc=0, imem_ready=1 immediately, rvalid next cycle with rdata=0x00500093 → inst=0x00500093, old_pc=0, pc=4, inst_valid=1 in cycle 3.
- imem_ready held low 5 cycles → imem_req and imem_addr=0x8 stable all 5 cycles; pc_write with pc_next=0x100 during REQ ignored, final pc=0xC.
- pc_write=1, pc_next=0x200 and fetch_start in the same IDLE cycle → imem_addr=0x200; after completion old_pc=0x200, pc=0x204.
- pc=0xFFFF_FFFF_FFFF_FFFC fetch → pc wraps to 0, old_pc=0xFFFF_FFFF_FFFF_FFFC.
- rst asserted in WAIT, then rvalid arrives → inst stays 0, pc=RESET_PC, inst_valid=0. With FETCH_ALIGN_CHECK_EN and pc=0x6, fetch_start → no imem_req, fetch_fault=1 until pc_write.
